axi4_mem_responder: RTL and testbench

AXI4_MEM_RESPONDER -- requirements
Module: axi4_mem_responder
Interface
REQ-001 DATA_WIDTH, 64, data bus width in bits; a power of two, at least 32.
REQ-002 ADDR_WIDTH, 32, byte address width.
REQ-003 LEN_WIDTH, 4, burst length field width; a burst is len+1 beats.
REQ-004 ID_WIDTH, 6, transaction ID width.
REQ-005 DEPTH_LOG2, 10, log2 of memory depth in DATA_WIDTH words.
REQ-006 DELAY_CYCLES, 4, address-to-data delay in cycles; used only when AXI4_MEM_RESPONDER_DELAY_EN is defined.
REQ-007 Clk  in  1  clock; all logic rising-edge.
REQ-008 Rst_n  in  1  reset, asynchronous, active-low.
REQ-009 s_awvalid  in  1  write address valid.
REQ-010 s_awready  out  1  write address ready.
REQ-011 s_awaddr  in  ADDR_WIDTH  write burst start byte address.
REQ-012 s_awlen  in  LEN_WIDTH  write burst length minus 1.
REQ-013 s_awid  in  ID_WIDTH  write transaction ID.
REQ-014 s_wvalid  in  1  write data valid.
REQ-015 s_wready  out  1  write data ready.
REQ-016 s_wdata  in  DATA_WIDTH  write data.
REQ-017 s_wstrb  in  DATA_WIDTH/8  byte enables.
REQ-018 s_wlast  in  1  last write beat.
REQ-019 s_bvalid  out  1  write response valid.
REQ-020 s_bready  in  1  write response ready.
REQ-021 s_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-022 s_bid  out  ID_WIDTH  write response ID.
REQ-023 s_arvalid  in  1  read address valid.
REQ-024 s_arready  out  1  read address ready.
REQ-025 s_araddr  in  ADDR_WIDTH  read burst start byte address.
REQ-026 s_arlen  in  LEN_WIDTH  read burst length minus 1.
REQ-027 s_arid  in  ID_WIDTH  read transaction ID.
REQ-028 s_rvalid  out  1  read data valid.
REQ-029 s_rready  in  1  read data ready.
REQ-030 s_rdata  out  DATA_WIDTH  read data.
REQ-031 s_rlast  out  1  last read beat.
REQ-032 s_rresp  out  2  read response; always 2'b00.
REQ-033 s_rid  out  ID_WIDTH  read ID.
Function
REQ-034 The block SHALL hold 2**DEPTH_LOG2 single-port words:
- word index = address bits above log2(DATA_WIDTH/8), taken modulo depth, so any address wraps silently with OKAY;
- writes are byte-masked by s_wstrb;
- reads have 1-cycle latency.
REQ-035 The FSM SHALL use states IDLE, WR_DATA, WR_RESP and RD_DATA, with one transaction in flight at a time.
REQ-036 s_awready and s_arready SHALL be high only in IDLE, for the granted channel only, and only when a registered enable flag is set.
- Simultaneous valids: grant alternates, starting with write after reset.
- Address handshake: latch addr/len/id and leave IDLE.
REQ-037 In WR_DATA, s_wready SHALL be 1:
- each beat writes the current word and increments the word address (INCR);
- after beat len+1, go to WR_RESP;
- s_wlast missing on the final beat, or asserted earlier, sets bresp 2'b10.
REQ-038 In WR_RESP, s_bvalid, s_bid and s_bresp SHALL stay stable until s_bready, then the FSM returns to IDLE.
REQ-039 In RD_DATA, the first s_rvalid SHALL occur 2 cycles after the AR handshake:
- s_rdata/s_rlast stay stable while s_rvalid && !s_rready;
- the address advances only on an accepted beat;
- s_rlast on beat len+1;
- IDLE after the last beat is accepted.
Reset
REQ-040 While Rst_n is low, all outputs SHALL be 0 and the FSM in IDLE; the ready enable flag sets one cycle after release.
- Reset mid-burst aborts the transaction.
- Memory contents are not cleared.
Configuration
REQ-041 With AXI4_MEM_RESPONDER_DELAY_EN defined, a DELAY state SHALL hold DELAY_CYCLES cycles after each AW/AR handshake before s_wready or the read fetch starts; DELAY_CYCLES=0 gives undefined-macro timing.
REQ-042 Without AXI4_MEM_RESPONDER_DELAY_EN, the DELAY state and counter SHALL be absent and timing is per REQ-037/039.
Verification
REQ-043 Write then read back:
- write awaddr 0x100, awlen 3, awid 5, data 0x11..0x44, wstrb 0xFF -> bvalid, bid 5, bresp 00;
- then read arid 9 -> 4 matching beats, rid 9, rlast on beat 4.
REQ-044 Byte-masked write: write all-ones to 0x0, then write 0 with wstrb 0x0F -> read returns 0xFFFFFFFF00000000.
REQ-045 8-beat read with rready toggling every cycle -> 8 beats in order, no loss or duplication, data stable while stalled.
REQ-046 awvalid and arvalid together, twice after reset -> write granted first, read granted second.
REQ-047 awlen 3 with wlast on beat 2 -> bresp 2'b10 after 4 beats.
REQ-048 Reset and delay:
- Rst_n low mid read -> rvalid 0 immediately, memory preserved;
- with macro defined and DELAY_CYCLES 4 -> first rvalid 6 cycles after AR handshake.

---
 rtl/axi4_mem_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_axi4_mem_responder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_responder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | axi4_mem_responder: single-port AXI4 memory slave, one burst in flight.  |
// | Optional DELAY state via AXI4_MEM_RESPONDER_DELAY_EN.                    |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module axi4_mem_responder #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int LEN_WIDTH    = 4,
  parameter int ID_WIDTH     = 6,
  parameter int DEPTH_LOG2   = 10,
  parameter int DELAY_CYCLES = 4
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [LEN_WIDTH-1:0]    s_awlen,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [1:0]              s_bresp,
  output logic [ID_WIDTH-1:0]     s_bid,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [LEN_WIDTH-1:0]    s_arlen,
  input  logic [ID_WIDTH-1:0]     s_arid,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic                    s_rlast,
  output logic [1:0]              s_rresp,
  output logic [ID_WIDTH-1:0]     s_rid
);

  localparam int c_strb_w   = DATA_WIDTH / 8;
  localparam int c_addr_lsb = $clog2(c_strb_w);
  localparam int c_depth    = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_RESP = 3'd2,
    RD_DATA = 3'd3
`ifdef AXI4_MEM_RESPONDER_DELAY_EN
    , DELAY = 3'd4
`endif
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_WIDTH-1:0] r_mem [c_depth];
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  r_ready_en;
  logic                  r_prio_wr;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_beat;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_wr_err;
  logic [1:0]            r_bresp;
  logic                  r_rd_primed;
  logic                  r_rvalid;
  logic                  r_rlast;

  logic                  w_grant_wr;
  logic                  w_grant_rd;
  logic                  w_aw_hs;
  logic                  w_ar_hs;
  logic                  w_w_hs;
  logic                  w_wr_last;
  logic                  w_wlast_err;
  logic                  w_rd_first;
  logic                  w_rd_next;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic                  w_unused_ok;

  // Round-robin only matters when both address channels are valid together.
  assign w_grant_wr = s_awvalid && (!s_arvalid || r_prio_wr);
  assign w_grant_rd = s_arvalid && (!s_awvalid || !r_prio_wr);

  assign s_awready = (r_state == IDLE) && r_ready_en && w_grant_wr;
  assign s_arready = (r_state == IDLE) && r_ready_en && w_grant_rd;
  assign s_wready  = (r_state == WR_DATA);
  assign s_bvalid  = (r_state == WR_RESP);
  assign s_bresp   = r_bresp;
  assign s_bid     = r_id;
  assign s_rvalid  = r_rvalid;
  assign s_rdata   = r_rvalid ? r_rdata : '0;
  assign s_rlast   = r_rlast;
  assign s_rresp   = 2'b00;
  assign s_rid     = r_id;

  assign w_aw_hs     = s_awvalid && s_awready;
  assign w_ar_hs     = s_arvalid && s_arready;
  assign w_w_hs      = s_wvalid && s_wready;
  assign w_wr_last   = (r_beat == r_len);
  assign w_wlast_err = (s_wlast != w_wr_last);

  // First fetch waits one primed cycle; later fetches overlap the accepted beat.
  assign w_rd_first = (r_state == RD_DATA) && !r_rvalid && r_rd_primed;
  assign w_rd_next  = (r_state == RD_DATA) && r_rvalid && s_rready && !r_rlast;
  assign w_rd_idx   = w_rd_next ? (r_addr + DEPTH_LOG2'(1)) : r_addr;

  assign w_unused_ok = ^{s_awaddr, s_araddr};

`ifdef AXI4_MEM_RESPONDER_DELAY_EN
  localparam int c_dly_w = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [c_dly_w-1:0] c_dly_last =
    c_dly_w'((DELAY_CYCLES > 0) ? (DELAY_CYCLES - 1) : 0);

  logic [c_dly_w-1:0] r_dly_cnt;
  logic               r_dly_rd;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_dly_cnt <= '0;
      r_dly_rd  <= 1'b0;
    end else if (w_aw_hs || w_ar_hs) begin
      r_dly_cnt <= '0;
      r_dly_rd  <= w_ar_hs;
    end else if (r_state == DELAY) begin
      r_dly_cnt <= r_dly_cnt + c_dly_w'(1);
    end
  end
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
`ifdef AXI4_MEM_RESPONDER_DELAY_EN
        if (w_aw_hs)      w_state_nxt = (DELAY_CYCLES == 0) ? WR_DATA : DELAY;
        else if (w_ar_hs) w_state_nxt = (DELAY_CYCLES == 0) ? RD_DATA : DELAY;
`else
        if (w_aw_hs)      w_state_nxt = WR_DATA;
        else if (w_ar_hs) w_state_nxt = RD_DATA;
`endif
      end
      WR_DATA: if (s_wvalid && w_wr_last) w_state_nxt = WR_RESP;
      WR_RESP: if (s_bready) w_state_nxt = IDLE;
      RD_DATA: if (r_rvalid && s_rready && r_rlast) w_state_nxt = IDLE;
`ifdef AXI4_MEM_RESPONDER_DELAY_EN
      DELAY:   if (r_dly_cnt == c_dly_last) w_state_nxt = r_dly_rd ? RD_DATA : WR_DATA;
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ready_en  <= 1'b0;
      r_prio_wr   <= 1'b1;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_id        <= '0;
      r_wr_err    <= 1'b0;
      r_bresp     <= 2'b00;
      r_rd_primed <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_aw_hs) begin
        r_addr    <= s_awaddr[c_addr_lsb +: DEPTH_LOG2];
        r_len     <= s_awlen;
        r_id      <= s_awid;
        r_beat    <= '0;
        r_wr_err  <= 1'b0;
        r_prio_wr <= 1'b0;
      end
      if (w_ar_hs) begin
        r_addr      <= s_araddr[c_addr_lsb +: DEPTH_LOG2];
        r_len       <= s_arlen;
        r_id        <= s_arid;
        r_beat      <= '0;
        r_rd_primed <= 1'b0;
        r_prio_wr   <= 1'b1;
      end
      if (w_w_hs) begin
        r_addr   <= r_addr + DEPTH_LOG2'(1);
        r_beat   <= r_beat + LEN_WIDTH'(1);
        r_wr_err <= r_wr_err | w_wlast_err;
        if (w_wr_last) r_bresp <= (r_wr_err || w_wlast_err) ? 2'b10 : 2'b00;
      end
      if (r_state == RD_DATA) begin
        if (!r_rvalid) begin
          if (!r_rd_primed) begin
            r_rd_primed <= 1'b1;
          end else begin
            r_rvalid <= 1'b1;
            r_rlast  <= (r_len == '0);
          end
        end else if (s_rready) begin
          if (r_rlast) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
          end else begin
            r_addr  <= w_rd_idx;
            r_beat  <= r_beat + LEN_WIDTH'(1);
            r_rlast <= ((r_beat + LEN_WIDTH'(1)) == r_len);
          end
        end
      end
    end
  end

  // Storage and its read register carry no reset so contents survive Rst_n.
  always_ff @(posedge Clk) begin
    if (w_w_hs) begin
      for (int b = 0; b < c_strb_w; b++) begin
        if (s_wstrb[b]) r_mem[r_addr][8*b +: 8] <= s_wdata[8*b +: 8];
      end
    end
    if (w_rd_first || w_rd_next) r_rdata <= r_mem[w_rd_idx];
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_mem_responder.sv
`default_nettype none
// Scoreboard bench for axi4_mem_responder: directed bursts, expectations queued at issue.
module tb_axi4_mem_responder;

  localparam int DW = 64;
`ifdef AXI4_MEM_RESPONDER_DELAY_EN
  localparam int RD_LAT = 6;
`else
  localparam int RD_LAT = 2;
`endif

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic          s_bvalid, s_bready, s_arvalid, s_arready;
  logic          s_rvalid, s_rready, s_rlast;
  logic [31:0]   s_awaddr, s_araddr;
  logic [3:0]    s_awlen, s_arlen;
  logic [5:0]    s_awid, s_arid, s_bid, s_rid;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [7:0]    s_wstrb;
  logic [1:0]    s_bresp, s_rresp;

  axi4_mem_responder #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .LEN_WIDTH(4), .ID_WIDTH(6),
    .DEPTH_LOG2(10), .DELAY_CYCLES(4)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awid(s_awid),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arid(s_arid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rlast(s_rlast), .s_rresp(s_rresp), .s_rid(s_rid)
  );

  always #5 Clk = ~Clk;

  typedef struct packed { logic [63:0] d; logic last; logic [5:0] id; } rexp_t;
  typedef struct packed { logic [5:0] id; logic [1:0] resp; } bexp_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [63:0] wbuf [16];
  logic [63:0] ebuf [16];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          rr_mode  = 0;   // 0: rready high, 1: toggling, 2: rready low

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic sel_ready(input int ch);
    case (ch)
      0:       return s_awready;
      1:       return s_wready;
      default: return s_arready;
    endcase
  endfunction

  // Wait for ready on channel ch, then step through the handshake edge.
  task automatic wait_hs(input int ch);
    int n = 0;
    #1;
    while (!sel_ready(ch) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_errs++;
      $display("FAIL handshake_timeout: channel %0d never ready", ch);
    end
    tick();
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      n_checks++;
      n_errs++;
      $display("FAIL drain_timeout: %0d b and %0d r responses outstanding", bq.size(), rq.size());
      bq.delete();
      rq.delete();
    end
  endtask

  task automatic do_w(input int nbeats, input logic [7:0] strb, input int wlast_at);
    for (int i = 0; i < nbeats; i++) begin
      s_wvalid = 1'b1;
      s_wdata  = wbuf[i];
      s_wstrb  = strb;
      s_wlast  = (i == wlast_at);
      wait_hs(1);
    end
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id,
                             input logic [7:0] strb, input int wlast_at, input logic [1:0] resp);
    bq.push_back('{id: id, resp: resp});
    s_awaddr = addr; s_awlen = len; s_awid = id; s_awvalid = 1'b1;
    wait_hs(0);
    s_awvalid = 1'b0;
    do_w(int'(len) + 1, strb, wlast_at);
    wait_drain();
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id);
    int cnt = 0;
    for (int i = 0; i <= int'(len); i++)
      rq.push_back('{d: ebuf[i], last: (i == int'(len)), id: id});
    s_araddr = addr; s_arlen = len; s_arid = id; s_arvalid = 1'b1;
    wait_hs(2);
    s_arvalid = 1'b0;
    while (!s_rvalid && cnt < 50) begin
      tick();
      cnt++;
    end
    check("rd_first_latency", cnt, RD_LAT);
    wait_drain();
  endtask

  initial forever begin
    @(posedge Clk);
    #1;
    if (rr_mode == 1)      s_rready = !s_rready;
    else if (rr_mode == 2) s_rready = 1'b0;
    else                   s_rready = 1'b1;
  end

  // Monitor: compares every accepted B/R transfer against the queued expectation.
  initial begin : monitor
    bexp_t       be;
    rexp_t       re;
    logic        stall_pend = 1'b0;
    logic [63:0] held_d = '0;
    logic        held_l = 1'b0;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) begin
          check("r_stall_valid", s_rvalid, 1);
          check("r_stall_data", s_rdata, held_d);
          check("r_stall_last", s_rlast, held_l);
          stall_pend = 1'b0;
        end
        if (s_rvalid && !s_rready) begin
          stall_pend = 1'b1;
          held_d = s_rdata;
          held_l = s_rlast;
        end
        if (s_bvalid && s_bready) begin
          if (bq.size() == 0) begin
            n_checks++; n_errs++;
            $display("FAIL b_unexpected: bid %h bresp %b with nothing expected", s_bid, s_bresp);
          end else begin
            be = bq.pop_front();
            check("bid", s_bid, be.id);
            check("bresp", s_bresp, be.resp);
          end
        end
        if (s_rvalid && s_rready) begin
          if (rq.size() == 0) begin
            n_checks++; n_errs++;
            $display("FAIL r_unexpected: rdata %h with nothing expected", s_rdata);
          end else begin
            re = rq.pop_front();
            check("rdata", s_rdata, re.d);
            check("rlast", s_rlast, re.last);
            check("rid", s_rid, re.id);
            check("rresp", s_rresp, 2'b00);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    Rst_n = 1'b0;
    s_awvalid = 0; s_awaddr = 0; s_awlen = 0; s_awid = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0;
    s_arvalid = 0; s_araddr = 0; s_arlen = 0; s_arid = 0;
    s_bready = 1'b1;
    s_rready = 1'b1;

    // Both address channels valid through reset: readys must stay low.
    s_awaddr = 32'h200; s_awlen = 0; s_awid = 6'd1; s_awvalid = 1'b1;
    s_araddr = 32'h200; s_arlen = 0; s_arid = 6'd2; s_arvalid = 1'b1;
    repeat (3) tick();
    check("reset_ctrl_outputs",
          {s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast, s_bresp, s_rresp}, 0);
    check("reset_ids", {s_bid, s_rid}, 0);
    check("reset_rdata", s_rdata, 0);
    Rst_n = 1'b1;
    #1;
    check("ready_en_after_release", s_awready, 0);
    tick();
    check("first_grant_awready", s_awready, 1);
    check("first_grant_arready", s_arready, 0);
    bq.push_back('{id: 6'd1, resp: 2'b00});
    tick();
    s_awvalid = 1'b0;
    wbuf[0] = 64'hA5A5_0001_0000_0200;
    do_w(1, 8'hFF, 0);
    wait_drain();
    s_awaddr = 32'h208; s_awlen = 0; s_awid = 6'd3; s_awvalid = 1'b1;
    #1;
    check("second_grant_arready", s_arready, 1);
    check("second_grant_awready", s_awready, 0);
    rq.push_back('{d: 64'hA5A5_0001_0000_0200, last: 1'b1, id: 6'd2});
    tick();
    s_arvalid = 1'b0;
    wait_drain();
    bq.push_back('{id: 6'd3, resp: 2'b00});
    wbuf[0] = 64'h5A5A_0002_0000_0208;
    wait_hs(0);
    s_awvalid = 1'b0;
    do_w(1, 8'hFF, 0);
    wait_drain();
    ebuf[0] = 64'h5A5A_0002_0000_0208;
    read_burst(32'h208, 4'd0, 6'd4);

    // Four-beat write and read-back.
    wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
    write_burst(32'h100, 4'd3, 6'd5, 8'hFF, 3, 2'b00);
    ebuf[0] = 64'h11; ebuf[1] = 64'h22; ebuf[2] = 64'h33; ebuf[3] = 64'h44;
    read_burst(32'h100, 4'd3, 6'd9);

    // Byte-masked overwrite of the low half.
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    write_burst(32'h0, 4'd0, 6'd7, 8'hFF, 0, 2'b00);
    wbuf[0] = 64'h0;
    write_burst(32'h0, 4'd0, 6'd7, 8'h0F, 0, 2'b00);
    ebuf[0] = 64'hFFFF_FFFF_0000_0000;
    read_burst(32'h0, 4'd0, 6'd10);

    // Address above memory size wraps to word 1.
    wbuf[0] = 64'h0000_0000_0000_CAFE;
    write_burst(32'h2008, 4'd0, 6'd6, 8'hFF, 0, 2'b00);
    ebuf[0] = 64'h0000_0000_0000_CAFE;
    read_burst(32'h8, 4'd0, 6'd8);

    // Eight-beat read with rready toggling every cycle.
    for (int i = 0; i < 8; i++) wbuf[i] = 64'h0BAD_0000_0000_1000 + 64'(i);
    write_burst(32'h400, 4'd7, 6'd11, 8'hFF, 7, 2'b00);
    ebuf[0] = 64'h0BAD_0000_0000_1000; ebuf[1] = 64'h0BAD_0000_0000_1001;
    ebuf[2] = 64'h0BAD_0000_0000_1002; ebuf[3] = 64'h0BAD_0000_0000_1003;
    ebuf[4] = 64'h0BAD_0000_0000_1004; ebuf[5] = 64'h0BAD_0000_0000_1005;
    ebuf[6] = 64'h0BAD_0000_0000_1006; ebuf[7] = 64'h0BAD_0000_0000_1007;
    rr_mode = 1;
    read_burst(32'h400, 4'd7, 6'd11);
    rr_mode = 0;

    // Early wlast yields SLVERR, held while bready is low.
    wbuf[0] = 64'h1; wbuf[1] = 64'h2; wbuf[2] = 64'h3; wbuf[3] = 64'h4;
    s_bready = 1'b0;
    bq.push_back('{id: 6'd12, resp: 2'b10});
    s_awaddr = 32'h600; s_awlen = 4'd3; s_awid = 6'd12; s_awvalid = 1'b1;
    wait_hs(0);
    s_awvalid = 1'b0;
    do_w(4, 8'hFF, 1);
    n = 0;
    while (!s_bvalid && n < 50) begin tick(); n++; end
    repeat (3) tick();
    check("bvalid_held", s_bvalid, 1);
    check("bresp_held", s_bresp, 2'b10);
    check("bid_held", s_bid, 6'd12);
    s_bready = 1'b1;
    wait_drain();

    // Reset in the middle of a stalled read.
    rr_mode = 2;
    tick();
    s_araddr = 32'h100; s_arlen = 4'd3; s_arid = 6'd13; s_arvalid = 1'b1;
    wait_hs(2);
    s_arvalid = 1'b0;
    n = 0;
    while (!s_rvalid && n < 50) begin tick(); n++; end
    check("rvalid_before_reset", s_rvalid, 1);
    Rst_n = 1'b0;
    #1;
    check("rvalid_async_reset", s_rvalid, 0);
    check("rdata_async_reset", s_rdata, 0);
    repeat (2) tick();
    Rst_n = 1'b1;
    rr_mode = 0;
    tick();
    ebuf[0] = 64'h11; ebuf[1] = 64'h22; ebuf[2] = 64'h33; ebuf[3] = 64'h44;
    read_burst(32'h100, 4'd3, 6'd14);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire
